bcd_scan_ctrl: RTL and testbench
================================

Name: bcd_scan_ctrl

Overview:
- Time-multiplexed scan controller for a multi-digit decimal lamp/LED bank.
- Holds NUM_DIGITS packed BCD digits and drives them one at a time through a single shared BCD-to-one-hot-decimal decoder.
- Asserts the matching digit strobe for each digit, with anti-ghost blanking, leading-zero suppression, tear-free updates and invalid-code flagging.
- Sits between the counter/arithmetic logic that produces BCD values and the display pins.

Parameters:
- NUM_DIGITS, 4, number of BCD digits scanned (2..8); digit 0 is least significant.
- PRESCALE, 1000, clock cycles per digit slot (min 3); includes the 1 blank cycle.
- BLANK_LZ, 1, 1 = suppress leading zeros; 0 = always show every digit.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = scanning, 0 = display dark.
- load  in  1  one-cycle strobe; capture bcd_in.
- bcd_in  in  4*NUM_DIGITS  packed BCD; digit k occupies bits [4k+3:4k].
- err_clr  in  1  clears the sticky err flag.
- digit_sel  out  NUM_DIGITS  one-hot digit strobe, active high; all-zero when blanked.
- dec_out  out  10  one-hot decimal lamp lines 0..9; all-zero when blanked or the code is invalid.
- bcd_cur  out  4  BCD code currently routed to the decoder.
- frame_done  out  1  one-cycle pulse at the end of each full scan.
- err  out  1  sticky flag: a code of 10..15 was scanned.

Behaviour:
- Reset (rst_n=0, async): state=IDLE. digit_sel=0, dec_out=0, bcd_cur=0, frame_done=0, err=0. shadow=0, active=0, pending=0, digit index=0, slot counter=0.
- All outputs are registered and change only on clk rising edges, except the asynchronous reset.
- States:
  - IDLE: outputs zero. When enable=1, go to BLANK on the next cycle with index=0.
  - BLANK: 1 cycle. digit_sel=0, dec_out=0, bcd_cur=active digit[index]. Then go to SHOW.
  - SHOW: PRESCALE-1 cycles. digit_sel[index]=1 unless the digit is suppressed. dec_out=decode(bcd_cur). At the last SHOW cycle, go to BLANK with index+1. If index=NUM_DIGITS-1, wrap index to 0 and pulse frame_done in that last SHOW cycle.
- enable=0 in any state: enter IDLE on the next edge, outputs zero, index and counter cleared. Re-enable always restarts at digit 0 with BLANK.
- Load handling:
  - load=1 copies bcd_in into shadow and sets pending.
  - active copies from shadow only at a frame start, i.e. entering BLANK with index=0 (from IDLE or on wrap).
  - load in the same cycle as frame_done: that bcd_in value is the one used for the next frame (bypass shadow).
  - Multiple loads within one frame: the last one wins.
- Leading-zero suppression (BLANK_LZ=1): digit k>0 is suppressed when active digits NUM_DIGITS-1..k are all 0. A suppressed digit holds digit_sel=0 and dec_out=0 for its whole slot, and slot timing is unchanged. Digit 0 is never suppressed, so the value 0 shows "0".
- Invalid codes 10..15: dec_out=0 and digit_sel is still asserted. err is set on the first SHOW cycle of that slot. err_clr clears err, but a set in the same cycle wins.
- Decoder: purely combinational, code n (0..9) gives dec_out[n]=1.

Decomposition:
- Shared package bcd_pkg holds:
  - DEC_W=10, BCD_W=4.
  - State enum {IDLE, BLANK, SHOW}.
  - Function is_valid_bcd.
- Sub-module bcd_onehot_dec: 4-bit code in, 10-bit one-hot out, zero for codes 10..15. Instanced once and shared across all digits.
- Controller FSM, prescaler, shadow/active registers and suppression logic live in bcd_scan_ctrl.

Test Plan (NUM_DIGITS=4, PRESCALE=4):
- Reset and enable: load 0x1234, enable=1 → sequence per digit is 1 blank cycle then 3 cycles with digit_sel=0001, dec_out[4]=1; then 0010/[3], 0100/[2], 1000/[1]. frame_done pulses every 16 cycles.
- Leading zeros: load 0x0070 → digits 3 and 2 dark (digit_sel=0) for their full slots, digit 1 shows 7, digit 0 shows 0. Same with BLANK_LZ=0 → digit 3 shows dec_out[0].
- Tear-free update: load 0x9999 mid-frame → the rest of the frame still shows the old value, the new value appears from the next digit-0 slot. Load coincident with frame_done → new value in the next frame.
- Invalid code: load 0x00A5 → digit 1 slot has digit_sel=0010 and dec_out=0, err=1 and stays set. err_clr then clears it. err_clr while re-scanning 0xA → err stays 1.
- Mid-operation control: drop enable during digit 2 SHOW → all outputs 0 next cycle. Re-enable → BLANK at digit 0. Assert rst_n=0 mid-frame → outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD digit scan controller.
// Holds code/lamp widths, the scan FSM state type and a BCD validity check.
package bcd_pkg;

    localparam int DEC_W = 10;
    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } state_e;

    function automatic logic is_valid_bcd(input logic [BCD_W-1:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_scan_ctrl_if.sv
// Control/display bundle between BCD producer, scan controller and pins.
// master: drives enable/load/bcd_in/err_clr; slave: drives display outputs.
interface bcd_scan_ctrl_if
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);

    logic                        enable;
    logic                        load;
    logic [BCD_W*NUM_DIGITS-1:0] bcd_in;
    logic                        err_clr;
    logic [NUM_DIGITS-1:0]       digit_sel;
    logic [DEC_W-1:0]            dec_out;
    logic [BCD_W-1:0]            bcd_cur;
    logic                        frame_done;
    logic                        err;

    modport master (
        output enable, load, bcd_in, err_clr,
        input  digit_sel, dec_out, bcd_cur, frame_done, err
    );

    modport slave (
        input  enable, load, bcd_in, err_clr,
        output digit_sel, dec_out, bcd_cur, frame_done, err
    );

endinterface

// File: rtl/bcd_onehot_dec.sv
// Combinational BCD to one-hot decimal lamp decoder.
// code: 4-bit BCD in; onehot: lamp n high for code n, all zero for 10..15.
module bcd_onehot_dec
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] code,
    output logic [DEC_W-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (is_valid_bcd(code)) begin
            onehot = DEC_W'(1) << code;
        end
    end

endmodule

// File: rtl/bcd_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit BCD lamp bank.
// Ports: clk, rst_n (async low) and bus (slave): enable, load, bcd_in,
// err_clr in; digit_sel, dec_out, bcd_cur, frame_done, err out.
module bcd_scan_ctrl
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 1000,
    parameter int BLANK_LZ   = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    bcd_scan_ctrl_if.slave  bus
);

    localparam int AW = BCD_W * NUM_DIGITS;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(PRESCALE);

    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_SHOW = CW'(1);

    state_e         state;
    state_e         state_n;
    logic [IW-1:0]  idx;
    logic [IW-1:0]  idx_n;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_n;
    logic           frame_start;

    logic [AW-1:0]  shadow;
    logic [AW-1:0]  active;
    logic [AW-1:0]  active_n;
    logic           pending;

    logic [BCD_W-1:0] code_n;
    logic [DEC_W-1:0] dec_n;
    logic             upper_zero;
    logic             sup_n;
    logic             show_n;
    logic             lamp_on;
    logic             fd_n;
    logic             err_set;

    // Slot counter: cnt 0 is the blank cycle, 1..PRESCALE-1 are SHOW.
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        cnt_n       = cnt;
        frame_start = 1'b0;
        if (!bus.enable) begin
            state_n = IDLE;
            idx_n   = '0;
            cnt_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_n     = BLANK;
                    idx_n       = '0;
                    cnt_n       = '0;
                    frame_start = 1'b1;
                end
                BLANK: begin
                    state_n = SHOW;
                    cnt_n   = cnt + CW'(1);
                end
                SHOW: begin
                    if (cnt == CNT_LAST) begin
                        state_n = BLANK;
                        cnt_n   = '0;
                        if (idx == IDX_LAST) begin
                            idx_n       = '0;
                            frame_start = 1'b1;
                        end else begin
                            idx_n = idx + IW'(1);
                        end
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    idx_n   = '0;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
        end
    end

    // A load coinciding with a frame start bypasses the shadow register.
    always_comb begin
        active_n = active;
        if (frame_start) begin
            if (bus.load) begin
                active_n = bus.bcd_in;
            end else if (pending) begin
                active_n = shadow;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else begin
            active <= active_n;
            if (bus.load) begin
                shadow <= bus.bcd_in;
            end
            if (frame_start) begin
                pending <= 1'b0;
            end else if (bus.load) begin
                pending <= 1'b1;
            end
        end
    end

    // Outputs are derived from next-cycle values so the registered
    // outputs line up with the state they describe.
    always_comb begin
        code_n = '0;
        if (state_n != IDLE) begin
            code_n = active_n[idx_n*BCD_W +: BCD_W];
        end
    end

    always_comb begin
        upper_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k >= int'(idx_n) && active_n[k*BCD_W +: BCD_W] != '0) begin
                upper_zero = 1'b0;
            end
        end
        sup_n = (BLANK_LZ != 0) && (idx_n != '0) && upper_zero;
    end

    assign show_n  = (state_n == SHOW);
    assign lamp_on = show_n && !sup_n;
    assign fd_n    = show_n && (cnt_n == CNT_LAST) && (idx_n == IDX_LAST);
    assign err_set = show_n && (cnt_n == CNT_SHOW) && !is_valid_bcd(code_n);

    bcd_onehot_dec u_dec (
        .code   (code_n),
        .onehot (dec_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.digit_sel  <= '0;
            bus.dec_out    <= '0;
            bus.bcd_cur    <= '0;
            bus.frame_done <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            bus.digit_sel  <= lamp_on ? (NUM_DIGITS'(1) << idx_n) : '0;
            bus.dec_out    <= lamp_on ? dec_n : '0;
            bus.bcd_cur    <= code_n;
            bus.frame_done <= fd_n;
            bus.err        <= err_set | (bus.err & ~bus.err_clr);
        end
    end

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Scoreboard bench for bcd_scan_ctrl, with and without zero blanking.
// Model: slot/phase arithmetic on elapsed enabled cycles.
module tb_bcd_scan_ctrl;
    import bcd_pkg::*;

    localparam int N = 4;
    localparam int P = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          en = 1'b0;
    logic          ld = 1'b0;
    logic [15:0]   din = '0;
    logic          clr = 1'b0;

    bcd_scan_ctrl_if #(.NUM_DIGITS(N)) bus_lz ();
    bcd_scan_ctrl_if #(.NUM_DIGITS(N)) bus_nz ();

    assign bus_lz.enable  = en;
    assign bus_lz.load    = ld;
    assign bus_lz.bcd_in  = din;
    assign bus_lz.err_clr = clr;
    assign bus_nz.enable  = en;
    assign bus_nz.load    = ld;
    assign bus_nz.bcd_in  = din;
    assign bus_nz.err_clr = clr;

    bcd_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(P), .BLANK_LZ(1)) dut_lz (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_lz)
    );

    bcd_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(P), .BLANK_LZ(0)) dut_nz (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_nz)
    );

    typedef struct {
        logic [N-1:0] sel;
        logic [9:0]   dec;
        logic [3:0]   cur;
        logic         fd;
        logic         err;
    } exp_t;

    exp_t q_lz[$];
    exp_t q_nz[$];

    int checks = 0;
    int errors = 0;

    // Model state: t counts cycles since scanning (re)started, -1 = dark.
    int          t = -1;
    logic [15:0] m_shadow = '0;
    logic [15:0] m_active = '0;
    logic        m_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step_model();
        exp_t e;
        int phase;
        int digit;
        logic [3:0] code;
        bit blank;
        bit sup;
        bit set;
        if (!en) begin
            t = -1;
            if (ld) m_shadow = din;
            m_err = m_err & ~clr;
            e.sel = '0;
            e.dec = '0;
            e.cur = '0;
            e.fd  = 1'b0;
            e.err = m_err;
            q_lz.push_back(e);
            q_nz.push_back(e);
            return;
        end
        t++;
        phase = t % P;
        digit = (t / P) % N;
        if (phase == 0 && digit == 0) m_active = ld ? din : m_shadow;
        if (ld) m_shadow = din;
        code  = 4'(m_active >> (4 * digit));
        blank = (phase == 0);
        set   = (phase == 1) && (code > 9);
        m_err = set | (m_err & ~clr);
        for (int lz = 0; lz < 2; lz++) begin
            sup   = (lz == 1) && (digit > 0) && ((m_active >> (4 * digit)) == 0);
            e.sel = (!blank && !sup) ? (N'(1) << digit) : '0;
            e.dec = (!blank && !sup && code <= 9) ? (10'(1) << code) : '0;
            e.cur = code;
            e.fd  = (digit == N - 1) && (phase == P - 1);
            e.err = m_err;
            if (lz == 1) q_lz.push_back(e);
            else q_nz.push_back(e);
        end
    endtask

    task automatic cyc(input logic e_v, input logic l_v,
                       input logic [15:0] d_v, input logic c_v);
        @(negedge clk);
        en  = e_v;
        ld  = l_v;
        din = d_v;
        clr = c_v;
        step_model();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, ".lz.sel"}, 32'(bus_lz.digit_sel), 32'h0);
        chk({tag, ".lz.dec"}, 32'(bus_lz.dec_out), 32'h0);
        chk({tag, ".lz.cur"}, 32'(bus_lz.bcd_cur), 32'h0);
        chk({tag, ".lz.fd"}, 32'(bus_lz.frame_done), 32'h0);
        chk({tag, ".lz.err"}, 32'(bus_lz.err), 32'h0);
        chk({tag, ".nz.sel"}, 32'(bus_nz.digit_sel), 32'h0);
        chk({tag, ".nz.dec"}, 32'(bus_nz.dec_out), 32'h0);
        chk({tag, ".nz.err"}, 32'(bus_nz.err), 32'h0);
    endtask

    // Reset lands off the clock edge; outputs must clear at once.
    task automatic async_reset();
        @(negedge clk);
        #2;
        en    = 1'b0;
        ld    = 1'b0;
        clr   = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_dark("async_rst");
        t        = -1;
        m_shadow = '0;
        m_active = '0;
        m_err    = 1'b0;
        q_lz.delete();
        q_nz.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 7) > 3) v[k*4 +: 4] = 4'($urandom_range(0, 15));
        end
        return v;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && q_lz.size() > 0 && q_nz.size() > 0) begin
                e = q_lz.pop_front();
                chk("lz.sel", 32'(bus_lz.digit_sel), 32'(e.sel));
                chk("lz.dec", 32'(bus_lz.dec_out), 32'(e.dec));
                chk("lz.cur", 32'(bus_lz.bcd_cur), 32'(e.cur));
                chk("lz.fd", 32'(bus_lz.frame_done), 32'(e.fd));
                chk("lz.err", 32'(bus_lz.err), 32'(e.err));
                e = q_nz.pop_front();
                chk("nz.sel", 32'(bus_nz.digit_sel), 32'(e.sel));
                chk("nz.dec", 32'(bus_nz.dec_out), 32'(e.dec));
                chk("nz.cur", 32'(bus_nz.bcd_cur), 32'(e.cur));
                chk("nz.fd", 32'(bus_nz.frame_done), 32'(e.fd));
                chk("nz.err", 32'(bus_nz.err), 32'(e.err));
            end
        end
    end

    initial begin : stim
        #1;
        rst_n = 1'b0;
        #3;
        chk_dark("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic scan of 1234.
        cyc(1'b0, 1'b1, 16'h1234, 1'b0);
        run(40);

        // Leading zeros.
        cyc(1'b1, 1'b1, 16'h0070, 1'b0);
        run(40);

        // Mid-frame update must not tear.
        run(6);
        cyc(1'b1, 1'b1, 16'h9999, 1'b0);
        run(30);

        // Load coincident with frame_done.
        for (int i = 0; i < N * P && ((t + 1) % (N * P)) != 0; i++) run(1);
        cyc(1'b1, 1'b1, 16'h4321, 1'b0);
        run(20);

        // Invalid code, then clear, then clear while rescanning it.
        cyc(1'b1, 1'b1, 16'h00A5, 1'b0);
        run(40);
        cyc(1'b1, 1'b0, 16'h0, 1'b1);
        run(3);
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 16'h0, 1'b1);
        run(10);

        // Drop enable during digit 2 SHOW, then restart.
        for (int i = 0; i < N * P && (t % (N * P)) != 2 * P + 1; i++) run(1);
        cyc(1'b0, 1'b0, 16'h0, 1'b0);
        cyc(1'b0, 1'b0, 16'h0, 1'b0);
        run(24);

        async_reset();
        cyc(1'b1, 1'b1, 16'h0305, 1'b0);
        run(20);
        async_reset();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 49) != 0),
                ($urandom_range(0, 11) == 0),
                rand_bcd(),
                ($urandom_range(0, 19) == 0));
        end

        @(negedge clk);
        en = 1'b0;
        ld = 1'b0;
        clr = 1'b0;
        @(posedge clk);
        #2;
        chk("drain", 32'(q_lz.size() + q_nz.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
